hilo_muldiv_seq: RTL
====================

# hilo_muldiv_seq

Sequential multiply/divide engine with architectural HI/LO registers for the EX stage of the MIPS pipeline. It accepts one operation at a time from EX and computes it over several cycles. It raises `busy` so the hazard unit stalls mfhi/mflo and further mult/div issue until the result lands. It also services mthi/mtlo writes and exposes HI/LO continuously for mfhi/mflo.

## Interface
Parameters:
- none; latencies and encodings are package constants.

Ports:
- clk  in  1  single clock, rising edge.
- rstN  in  1  asynchronous, active-low reset.
- start  in  1  launches the operation on `mdOp`/`din1`/`din2`; only honoured when `busy`=0 and `flush`=0.
- mdOp  in  4  operation code:
  - 0000 = div
  - 0001 = divu
  - 0010 = mult
  - 0011 = multu
  - any other code with `start` is ignored.
- din1  in  32  rs operand: dividend or multiplicand.
- din2  in  32  rt operand: divisor or multiplier.
- hiWe  in  1  mthi write enable.
- loWe  in  1  mtlo write enable.
- wdata  in  32  mthi/mtlo data.
- flush  in  1  exception/branch kill; aborts any in-flight operation.
- busy  out  1  operation in flight; reset 0.
- doutHi  out  32  HI register; reset 0.
- doutLo  out  32  LO register; reset 0.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE → MUL on `start` with mult/multu.
- IDLE → DIV on `start` with div/divu.
- DIV → FIX after 32 iterations.
- MUL → IDLE and FIX → IDLE on completion, writing HI/LO.
- Any state → IDLE on `flush`; HI/LO unchanged.
- Operands are latched at accept, so later changes to `din1`/`din2` have no effect.
- mult/multu: full 64-bit product, HI = [63:32], LO = [31:0].
  - Signed: two's-complement magnitudes, product negated if the operand signs differ.
- div/divu: 32-iteration restoring division on unsigned magnitudes.
  - FIX applies signs: quotient negated if signs differ; remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divide by zero (both signedness): LO = 0xFFFFFFFF, HI = din1, sign fix skipped.
- 0x80000000 / 0xFFFFFFFF signed: LO = 0x80000000, HI = 0 (wraps, no trap).
- `hiWe`/`loWe` in IDLE write `wdata` to HI/LO at the next edge. Both may be asserted together.
- `hiWe`/`loWe` while `busy`=1 are ignored; the hazard unit must stall them.
- `start` and `hiWe`/`loWe` in the same IDLE cycle: `start` wins, the write is dropped.
- `start` while `busy`=1 is ignored.
- `flush` and `start` in the same cycle: `start` is ignored.
- Reset mid-operation: state IDLE, `busy` 0, HI/LO 0 immediately (asynchronous).

## Timing
- Accept edge: the edge where `start`=1 and `busy`=0. `busy` is 1 from the following cycle.
- div/divu: `busy` high exactly 33 cycles (32 iterations + FIX). HI/LO update on the edge where `busy` falls.
- mult/multu: `busy` high 32 cycles (iterative shift-add); HI/LO update as `busy` falls.
- New HI/LO are visible on `doutHi`/`doutLo` the cycle `busy` reads 0. No bypass from the in-flight datapath.
- Back-to-back ops: the next `start` may be accepted in the first cycle `busy`=0.
- `flush`: `busy` is 0 the cycle after `flush`.

## Configuration
- `MD_FAST_MULT_EN` defined:
  - mult/multu use a single-cycle 32×32 multiplier; `busy` is high exactly 1 cycle.
  - MUL lasts one cycle.
- Undefined: 32-cycle iterative shift-add multiply, as above.
- Division latency and all other behaviour are identical in both builds.

## Structure
- Package `md_pkg` holds:
  - op encodings: `MD_DIV`, `MD_DIVU`, `MD_MULT`, `MD_MULTU`;
  - state enum `md_state_t`;
  - constants `MD_DIV_CYCLES`=33, `MD_MUL_CYCLES`=32/1;
  - an iteration-counter width of 6.
- One sub-module `div_iter`: a restoring-divide step engine (load, 32 shift/subtract steps, done). It returns unsigned quotient and remainder to the parent.
- The parent owns the FSM, sign handling, multiply path and HI/LO registers.

## Test plan
- Reset with `rstN`=0 mid-DIV → `busy`=0, `doutHi`=`doutLo`=0 immediately; the engine stays idle after release.
- mult: 0xFFFFFFFE × 0x00000003 → after 32 busy cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
  - With `MD_FAST_MULT_EN`, the same results after 1 busy cycle.
- div -7 / 2 → 33 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 100 / 7 → LO=14, HI=2.
- div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234.
- mthi 0xDEADBEEF in IDLE → next cycle `doutHi`=0xDEADBEEF.
  - `loWe` during busy → LO unchanged; `start` during busy → no effect.
  - `start`+`hiWe` together in IDLE → op runs, the write is dropped.
- `flush` at busy cycle 10 of a div → `busy`=0 next cycle, HI/LO keep their prior values.
  - A new `start` that cycle is accepted normally.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared encodings, states and latencies for the HI/LO multiply/divide engine.
// MD_FAST_MULT_EN selects the single-cycle multiplier latency.
package md_pkg;
   localparam logic [3:0] MD_DIV   = 4'b0000;
   localparam logic [3:0] MD_DIVU  = 4'b0001;
   localparam logic [3:0] MD_MULT  = 4'b0010;
   localparam logic [3:0] MD_MULTU = 4'b0011;
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;
   localparam int MD_DIV_CYCLES = 33;
`ifdef MD_FAST_MULT_EN
   localparam int MD_MUL_CYCLES = 1;
`else
   localparam int MD_MUL_CYCLES = 32;
`endif
   localparam int MD_CNT_W = 6;
   // Two's-complement magnitude when the operand is treated as signed.
   function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? -v : v;
   endfunction
endpackage

// File: rtl/div_iter.sv
// div_iter: unsigned restoring divider, one shift/subtract step per cycle after load.
// `last` is high in the cycle whose edge performs the 32nd step.
module div_iter
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        rstN,
   input  logic        load,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        last
);
   localparam logic [MD_CNT_W-1:0] STEPS = MD_CNT_W'(MD_DIV_CYCLES - 1);
   logic [MD_CNT_W-1:0] cnt;
   logic [31:0] q, r, d;
   logic [32:0] sh, diff;
   assign sh = {r, q[31]};
   assign diff = sh - {1'b0, d};
   assign quotient = q;
   assign remainder = r;
   assign last = cnt == STEPS - 1'b1;
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         cnt <= STEPS;
         q <= '0;
         r <= '0;
         d <= '0;
      end else if (load) begin
         cnt <= '0;
         q <= dividend;
         r <= '0;
         d <= divisor;
      end else if (cnt != STEPS) begin
         // a borrow means the trial subtraction failed, so the shifted value is kept
         q <= {q[30:0], ~diff[32]};
         r <= diff[32] ? sh[31:0] : diff[31:0];
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: multi-cycle MIPS mult/div engine owning the HI/LO registers.
// MD_FAST_MULT_EN swaps the 32-step shift-add multiply for a single-cycle multiplier.
module hilo_muldiv_seq
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        rstN,
   input  logic        start,
   input  logic [3:0]  mdOp,
   input  logic [31:0] din1,
   input  logic [31:0] din2,
   input  logic        hiWe,
   input  logic        loWe,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] doutHi,
   output logic [31:0] doutLo
);
   md_state_t state;
   logic [MD_CNT_W-1:0] cnt;
   logic [31:0] opA, mcand, quo, rem;
   logic [63:0] prod, prodStep, mulRes;
   logic [32:0] sum;
   logic negRes, negRem, divZero, divLast, mulLast;
   logic isMul, isDiv, sgn, accept;
   assign isMul = mdOp == MD_MULT || mdOp == MD_MULTU;
   assign isDiv = mdOp == MD_DIV || mdOp == MD_DIVU;
   assign sgn = mdOp == MD_DIV || mdOp == MD_MULT;
   assign accept = start && state == IDLE && !flush && (isMul || isDiv);
   // shift-add step: HI half accumulates the multiplicand, multiplier bits retire from LO
   assign sum = {1'b0, prod[63:32]} + {1'b0, prod[0] ? mcand : 32'd0};
   assign prodStep = {sum, prod[31:1]};
   assign mulLast = cnt == MD_CNT_W'(MD_MUL_CYCLES - 1);
`ifdef MD_FAST_MULT_EN
   assign mulRes = {32'd0, mcand} * {32'd0, prod[31:0]};
`else
   assign mulRes = prodStep;
`endif
   div_iter uDiv (
      .clk(clk),
      .rstN(rstN),
      .load(accept && isDiv),
      .dividend(mag(din1, sgn)),
      .divisor(mag(din2, sgn)),
      .quotient(quo),
      .remainder(rem),
      .last(divLast)
   );
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= IDLE;
         busy <= 1'b0;
         doutHi <= '0;
         doutLo <= '0;
         cnt <= '0;
         opA <= '0;
         mcand <= '0;
         prod <= '0;
         negRes <= 1'b0;
         negRem <= 1'b0;
         divZero <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= isMul ? MUL : DIV;
                  busy <= 1'b1;
                  cnt <= '0;
                  opA <= din1;
                  mcand <= mag(din1, sgn);
                  prod <= {32'd0, mag(din2, sgn)};
                  negRes <= sgn && (din1[31] ^ din2[31]);
                  negRem <= sgn && din1[31];
                  divZero <= din2 == '0;
               end else begin
                  if (hiWe) doutHi <= wdata;
                  if (loWe) doutLo <= wdata;
               end
            end
            MUL: begin
               prod <= prodStep;
               cnt <= cnt + 1'b1;
               if (mulLast) begin
                  {doutHi, doutLo} <= negRes ? -mulRes : mulRes;
                  state <= IDLE;
                  busy <= 1'b0;
               end
            end
            DIV: if (divLast) state <= FIX;
            FIX: begin
               doutHi <= divZero ? opA : (negRem ? -rem : rem);
               doutLo <= divZero ? '1 : (negRes ? -quo : quo);
               state <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end
endmodule
